// File: rtl/sv32_ptw.sv
// Sv32 page table walker: one walk in flight, returns leaf PTE or page fault.
// Define SV32_PTW_SUPERPAGE_ALIGN_CHECK_EN to fault misaligned superpage leaves.
module sv32_ptw #(
    parameter int VPN_WIDTH  = 20,
    parameter int PPN_WIDTH  = 22,
    parameter int PA_WIDTH   = 34,
    parameter int ASID_WIDTH = 9
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PPN_WIDTH-1:0]  satp_PPN,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [VPN_WIDTH-1:0]  req_VPN,
    input  logic [ASID_WIDTH-1:0] req_ASID,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [PA_WIDTH-1:0]   mem_req_PA,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_PTE,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [VPN_WIDTH-1:0]  resp_VPN,
    output logic [ASID_WIDTH-1:0] resp_ASID,
    output logic [31:0]           resp_PTE,
    output logic                  resp_superpage,
    output logic                  resp_page_fault
);

    localparam int VH = VPN_WIDTH / 2;

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [VPN_WIDTH-1:0]  vpn_q, vpn_d;
    logic [ASID_WIDTH-1:0] asid_q, asid_d;
    logic [PA_WIDTH-1:0]   pa_q, pa_d;
    logic [31:0]           pte_q, pte_d;
    logic                  sp_q, sp_d;
    logic                  pf_q, pf_d;

    logic pte_bad, pte_leaf, sp_misalign, at_l1;

    assign pte_bad  = !mem_resp_PTE[0] || (mem_resp_PTE[2] && !mem_resp_PTE[1]);
    assign pte_leaf = mem_resp_PTE[1] || mem_resp_PTE[3];
    assign at_l1    = (state_q == L1_WAIT);

`ifdef SV32_PTW_SUPERPAGE_ALIGN_CHECK_EN
    assign sp_misalign = |mem_resp_PTE[19:10];
`else
    assign sp_misalign = 1'b0;
`endif

    // RST gates ready so nothing is accepted while reset is held
    assign req_ready     = (state_q == IDLE) && !flush && !RST;
    assign mem_req_valid = ((state_q == L1_REQ) || (state_q == L0_REQ)) && !flush;
    assign resp_valid    = (state_q == RESP) && !flush;

    assign mem_req_PA      = pa_q;
    assign resp_VPN        = vpn_q;
    assign resp_ASID       = asid_q;
    assign resp_PTE        = pte_q;
    assign resp_superpage  = sp_q;
    assign resp_page_fault = pf_q;

    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        asid_d  = asid_q;
        pa_d    = pa_q;
        pte_d   = pte_q;
        sp_d    = sp_q;
        pf_d    = pf_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    vpn_d   = req_VPN;
                    asid_d  = req_ASID;
                    pa_d    = {satp_PPN, req_VPN[VPN_WIDTH-1:VH], 2'b00};
                    state_d = L1_REQ;
                end
            end
            L1_REQ, L0_REQ: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_req_ready) begin
                    state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end
            L1_WAIT, L0_WAIT: begin
                if (flush) begin
                    state_d = mem_resp_valid ? IDLE : DRAIN;
                end else if (mem_resp_valid) begin
                    state_d = RESP;
                    pte_d   = '0;
                    sp_d    = 1'b0;
                    pf_d    = 1'b1;
                    if (!pte_bad && pte_leaf) begin
                        if (!(at_l1 && sp_misalign)) begin
                            pte_d = mem_resp_PTE;
                            sp_d  = at_l1;
                            pf_d  = 1'b0;
                        end
                    end else if (!pte_bad && at_l1) begin
                        pa_d    = {mem_resp_PTE[31:10], vpn_q[VH-1:0], 2'b00};
                        state_d = L0_REQ;
                    end
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            vpn_q   <= '0;
            asid_q  <= '0;
            pa_q    <= '0;
            pte_q   <= '0;
            sp_q    <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            asid_q  <= asid_d;
            pa_q    <= pa_d;
            pte_q   <= pte_d;
            sp_q    <= sp_d;
            pf_q    <= pf_d;
        end
    end

endmodule

// File: tb/tb_sv32_ptw.sv
// Scoreboard bench for sv32_ptw: directed walks, flushes, backpressure, random walks.
module tb_sv32_ptw;

    logic        CLK = 0;
    logic        RST;
    logic [21:0] satp_PPN;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_VPN;
    logic [8:0]  req_ASID;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [33:0] mem_req_PA;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_PTE;
    logic        resp_valid;
    logic        resp_ready;
    logic [19:0] resp_VPN;
    logic [8:0]  resp_ASID;
    logic [31:0] resp_PTE;
    logic        resp_superpage;
    logic        resp_page_fault;

    sv32_ptw dut (
        .CLK(CLK), .RST(RST), .satp_PPN(satp_PPN), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_VPN(req_VPN),
        .req_ASID(req_ASID), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_PA(mem_req_PA),
        .mem_resp_valid(mem_resp_valid), .mem_resp_PTE(mem_resp_PTE),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_VPN(resp_VPN), .resp_ASID(resp_ASID), .resp_PTE(resp_PTE),
        .resp_superpage(resp_superpage), .resp_page_fault(resp_page_fault)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [19:0] vpn;
        logic [8:0]  asid;
        logic [31:0] pte;
        logic        sp;
        logic        pf;
    } res_t;

    typedef struct {
        logic [33:0] pa;
        int          due;
    } pend_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rise_cyc = 0;

    logic [31:0] pmem [logic [33:0]];
    res_t        exp_q [$];
    logic [33:0] pa_q [$];
    pend_t       pend [$];

    int mem_lat = 1;
    int mem_stall = 0;
    bit mem_rand_ready = 0;
    bit rr_low = 0;
    bit rr_rand = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s t=%0t", nm, $time);
    endtask

    function automatic logic [31:0] rd(input logic [33:0] a);
        return pmem.exists(a) ? pmem[a] : 32'h0;
    endfunction

    // Reference walk straight from the Sv32 rules
    function automatic void model(input logic [21:0] satp, input logic [19:0] vpn,
                                  input logic [8:0] asid);
        logic [33:0] a1, a0;
        logic [31:0] p, q;
        res_t r;
        a1 = {satp, vpn[19:10], 2'b00};
        pa_q.push_back(a1);
        p = rd(a1);
        r = '{vpn: vpn, asid: asid, pte: 32'h0, sp: 1'b0, pf: 1'b1};
        if (!p[0] || (p[2] && !p[1])) begin
            r.pf = 1'b1;
        end else if (p[1] || p[3]) begin
`ifdef SV32_PTW_SUPERPAGE_ALIGN_CHECK_EN
            if (p[19:10] == 10'd0) begin
                r.pte = p; r.sp = 1'b1; r.pf = 1'b0;
            end
`else
            r.pte = p; r.sp = 1'b1; r.pf = 1'b0;
`endif
        end else begin
            a0 = {p[31:10], vpn[9:0], 2'b00};
            pa_q.push_back(a0);
            q = rd(a0);
            if (q[0] && !(q[2] && !q[1]) && (q[1] || q[3])) begin
                r.pte = q; r.pf = 1'b0;
            end
        end
        exp_q.push_back(r);
    endfunction

    function automatic logic [31:0] rand_pte(input int kind, input bit lvl1);
        logic [31:0] x;
        x = $urandom;
        case (kind)
            0: x[0] = 1'b0;
            1: x[2:0] = 3'b101;
            2: begin
                if (x[4]) x[1:0] = 2'b11;
                else x[3:0] = 4'b1001;
                if (lvl1 && x[5]) x[19:10] = 10'd0;
            end
            default: x[3:0] = 4'b0001;
        endcase
        return x;
    endfunction

    // Memory responder and request-side checker
    initial begin : mem_model
        bit prev_mv, prev_mr;
        logic [33:0] prev_pa;
        int lat, due, last_due;
        prev_mv = 0; prev_mr = 0; prev_pa = '0; last_due = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_PTE = '0;
        forever begin
            @(posedge CLK); #1;
            if (mem_stall > 0) begin
                mem_req_ready = 1'b0;
                mem_stall--;
            end else begin
                mem_req_ready = mem_rand_ready ? ($urandom % 3 != 0) : 1'b1;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_resp_PTE = rd(pend[0].pa);
                pend.delete(0);
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_PTE = $urandom;
            end
            @(negedge CLK);
            if (!RST) begin
                if (prev_mv && !prev_mr && mem_req_valid)
                    chk("mem_pa_stable", 64'(mem_req_PA), 64'(prev_pa));
                if (mem_req_valid && mem_req_ready) begin
                    lat = (mem_lat > 0) ? mem_lat : $urandom_range(1, 3);
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend.push_back('{mem_req_PA, due});
                    if (pa_q.size() == 0) fail("mem_unexpected");
                    else chk("mem_pa", 64'(mem_req_PA), 64'(pa_q.pop_front()));
                end
            end
            prev_mv = mem_req_valid && !RST;
            prev_mr = mem_req_ready;
            prev_pa = mem_req_PA;
        end
    end

    initial begin : rr_drv
        resp_ready = 1'b1;
        forever begin
            @(posedge CLK); #1;
            resp_ready = rr_low ? 1'b0 : (rr_rand ? ($urandom % 3 != 0) : 1'b1);
        end
    end

    // Response monitor: pops the scoreboard on each handshake
    initial begin : resp_mon
        res_t got, prevb;
        bit pv, pr;
        pv = 0; pr = 0; prevb = '0;
        forever begin
            @(negedge CLK);
            got = {resp_VPN, resp_ASID, resp_PTE, resp_superpage, resp_page_fault};
            if (!RST && resp_valid) begin
                if (!pv) rise_cyc = cyc;
                if (pv && !pr) chk("resp_stable", 64'(got), 64'(prevb));
                if (resp_ready) begin
                    if (exp_q.size() == 0) fail("resp_unexpected");
                    else chk("resp", 64'(got), 64'(exp_q.pop_front()));
                end
            end
            pv = resp_valid && !RST;
            pr = resp_ready;
            prevb = got;
        end
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic issue(input logic [19:0] vpn, input logic [8:0] asid,
                         input logic [21:0] satp, input int stall);
        int n;
        bit ok;
        n = 0; ok = 0;
        step();
        req_valid = 1'b1; req_VPN = vpn; req_ASID = asid; satp_PPN = satp;
        while (!ok && n < 100) begin
            @(negedge CLK);
            if (req_ready) begin
                ok = 1; acc_cyc = cyc; mem_stall = stall;
            end else begin
                step(); n++;
            end
        end
        if (!ok) fail("issue_timeout");
        step();
        req_valid = 1'b0; req_VPN = $urandom; satp_PPN = $urandom; req_ASID = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while (!(req_ready && exp_q.size() == 0 && pa_q.size() == 0 && pend.size() == 0)
               && n < 300) begin
            @(negedge CLK); n++;
        end
        if (n >= 300) fail("idle_timeout");
    endtask

    initial begin : main
        int vcnt;
        bit done;
        logic [21:0] satp;
        logic [19:0] vpn;
        logic [31:0] p1;
        RST = 1; flush = 0; req_valid = 0; req_VPN = '0; req_ASID = '0; satp_PPN = '0;
        repeat (2) @(negedge CLK);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_mem_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp", 64'({resp_VPN, resp_ASID, resp_PTE, resp_superpage, resp_page_fault}), 64'(0));
        chk("rst_pa", 64'(mem_req_PA), 64'(0));
        step();
        RST = 0;
        @(negedge CLK);
        chk("post_rst_ready", 64'(req_ready), 64'(1));

        // Superpage walk
        pmem.delete(); pmem[34'h1400] = 32'h0040000F;
        pa_q.push_back(34'h0000_1400);
        exp_q.push_back({20'h40123, 9'h05, 32'h0040000F, 1'b1, 1'b0});
        issue(20'h40123, 9'h05, 22'h1, 0);
        wait_idle();
        chk("lat_super", 64'(rise_cyc - acc_cyc), 64'(3));

        // Two-level walk
        pmem[34'h1400] = 32'h00000801; pmem[34'h248C] = 32'h0000300B;
        pa_q.push_back(34'h0000_1400); pa_q.push_back(34'h0000_248C);
        exp_q.push_back({20'h40123, 9'h1A0, 32'h0000300B, 1'b0, 1'b0});
        issue(20'h40123, 9'h1A0, 22'h1, 0);
        wait_idle();
        chk("lat_two", 64'(rise_cyc - acc_cyc), 64'(5));

        // Faults: invalid L1, pointer at L0, W without R
        pmem[34'h1400] = 32'h00000000;
        pa_q.push_back(34'h1400);
        exp_q.push_back({20'h40123, 9'h3, 32'h0, 1'b0, 1'b1});
        issue(20'h40123, 9'h3, 22'h1, 0);
        wait_idle();
        pmem[34'h1400] = 32'h00000801; pmem[34'h248C] = 32'h00000801;
        pa_q.push_back(34'h1400); pa_q.push_back(34'h248C);
        exp_q.push_back({20'h40123, 9'h4, 32'h0, 1'b0, 1'b1});
        issue(20'h40123, 9'h4, 22'h1, 0);
        wait_idle();
        pmem[34'h1400] = 32'h00000005;
        pa_q.push_back(34'h1400);
        exp_q.push_back({20'h40123, 9'h6, 32'h0, 1'b0, 1'b1});
        issue(20'h40123, 9'h6, 22'h1, 0);
        wait_idle();

        // Misaligned superpage
        pmem[34'h1400] = 32'h0040040F;
        pa_q.push_back(34'h1400);
`ifdef SV32_PTW_SUPERPAGE_ALIGN_CHECK_EN
        exp_q.push_back({20'h40123, 9'h7, 32'h0, 1'b0, 1'b1});
`else
        exp_q.push_back({20'h40123, 9'h7, 32'h0040040F, 1'b1, 1'b0});
`endif
        issue(20'h40123, 9'h7, 22'h1, 0);
        wait_idle();

        // Backpressure on both memory and response sides
        pmem[34'h1400] = 32'h00000801; pmem[34'h248C] = 32'h0000300B;
        pa_q.push_back(34'h1400); pa_q.push_back(34'h248C);
        exp_q.push_back({20'h40123, 9'h8, 32'h0000300B, 1'b0, 1'b0});
        rr_low = 1;
        issue(20'h40123, 9'h8, 22'h1, 3);
        vcnt = 0; done = 0;
        for (int n = 0; n < 80 && !done; n++) begin
            @(negedge CLK);
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            if (resp_valid) vcnt++;
            if (resp_valid && resp_ready) done = 1;
            if (vcnt == 4) rr_low = 0;
        end
        if (!done) fail("bp_timeout");
        chk("bp_valid_cycles", 64'(vcnt), 64'(5));
        chk("bp_lat", 64'(rise_cyc - acc_cyc), 64'(8));
        rr_low = 0;
        wait_idle();

        // Flush in L1_WAIT, response two cycles later is drained
        pmem[34'h1400] = 32'h0040000F;
        mem_lat = 3;
        pa_q.push_back(34'h1400);
        issue(20'h40123, 9'h9, 22'h1, 0);
        step(); flush = 1;
        step(); flush = 0;
        @(negedge CLK);
        chk("fw_c3_ready", 64'(req_ready), 64'(0));
        chk("fw_c3_resp", 64'(resp_valid), 64'(0));
        step(); @(negedge CLK);
        chk("fw_c4_ready", 64'(req_ready), 64'(0));
        step(); @(negedge CLK);
        chk("fw_c5_ready", 64'(req_ready), 64'(1));
        chk("fw_c5_resp", 64'(resp_valid), 64'(0));
        mem_lat = 1;
        wait_idle();

        // Flush coincident with the L1 response
        pa_q.push_back(34'h1400);
        issue(20'h40123, 9'hA, 22'h1, 0);
        step(); flush = 1;
        step(); flush = 0;
        @(negedge CLK);
        chk("fc_ready", 64'(req_ready), 64'(1));
        wait_idle();

        // Flush in L1_REQ
        issue(20'h40123, 9'hB, 22'h1, 0);
        flush = 1;
        @(negedge CLK);
        chk("fq_mem_valid", 64'(mem_req_valid), 64'(0));
        step(); flush = 0;
        @(negedge CLK);
        chk("fq_ready", 64'(req_ready), 64'(1));
        wait_idle();

        // Flush in RESP
        rr_low = 1;
        pa_q.push_back(34'h1400);
        issue(20'h40123, 9'hC, 22'h1, 0);
        step(); step(); @(negedge CLK);
        chk("fr_valid", 64'(resp_valid), 64'(1));
        step(); flush = 1;
        @(negedge CLK);
        chk("fr_drop", 64'(resp_valid), 64'(0));
        step(); flush = 0;
        @(negedge CLK);
        chk("fr_ready", 64'(req_ready), 64'(1));
        chk("fr_gone", 64'(resp_valid), 64'(0));
        rr_low = 0;
        wait_idle();

        // Randomized walks with random latency and backpressure
        mem_lat = 0; mem_rand_ready = 1; rr_rand = 1;
        for (int i = 0; i < 60; i++) begin
            wait_idle();
            satp = $urandom;
            vpn = $urandom;
            p1 = rand_pte($urandom % 5, 1'b1);
            pmem[{satp, vpn[19:10], 2'b00}] = p1;
            if (p1[3:0] == 4'b0001)
                pmem[{p1[31:10], vpn[9:0], 2'b00}] = rand_pte($urandom % 5, 1'b0);
            model(satp, vpn, 9'($urandom));
            issue(vpn, exp_q[exp_q.size() - 1].asid, satp, 0);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
